// File: rtl/bn_pkg.sv
// Shared encodings, FSM states and helpers for the batch-normalization sequencer slice.
package bn_pkg;

    localparam logic [1:0] PSEL_GAMMA = 2'd0;
    localparam logic [1:0] PSEL_BETA  = 2'd1;
    localparam logic [1:0] PSEL_MEAN  = 2'd2;
    localparam logic [1:0] PSEL_DENOM = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic valid;
        logic last;
    } tag_t;

    // Index width that stays legal (>=1 bit) even for a single-entry range.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bn_param_bank.sv
// Per-channel gamma/beta/mean/denominator register file with one write port
// and one asynchronous read port returning all four values for a channel.
module bn_param_bank
    import bn_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CHANNELS   = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  we_i,
    input  logic [1:0]            sel_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] gamma_o,
    output logic [DATA_WIDTH-1:0] beta_o,
    output logic [DATA_WIDTH-1:0] mean_o,
    output logic [DATA_WIDTH-1:0] denom_o
);

    logic [DATA_WIDTH-1:0] gamma_q [CHANNELS];
    logic [DATA_WIDTH-1:0] gamma_d [CHANNELS];
    logic [DATA_WIDTH-1:0] beta_q  [CHANNELS];
    logic [DATA_WIDTH-1:0] beta_d  [CHANNELS];
    logic [DATA_WIDTH-1:0] mean_q  [CHANNELS];
    logic [DATA_WIDTH-1:0] mean_d  [CHANNELS];
    logic [DATA_WIDTH-1:0] denom_q [CHANNELS];
    logic [DATA_WIDTH-1:0] denom_d [CHANNELS];

    always_comb begin
        gamma_d = gamma_q;
        beta_d  = beta_q;
        mean_d  = mean_q;
        denom_d = denom_q;
        // Addresses beyond the channel count are dropped rather than aliased.
        if (we_i && (32'(waddr_i) < CHANNELS)) begin
            case (sel_i)
                PSEL_GAMMA: gamma_d[waddr_i] = wdata_i;
                PSEL_BETA:  beta_d[waddr_i]  = wdata_i;
                PSEL_MEAN:  mean_d[waddr_i]  = wdata_i;
                PSEL_DENOM: denom_d[waddr_i] = wdata_i;
                default:    gamma_d = gamma_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                gamma_q[i] <= '0;
                beta_q[i]  <= '0;
                mean_q[i]  <= '0;
                denom_q[i] <= '0;
            end
        end else begin
            gamma_q <= gamma_d;
            beta_q  <= beta_d;
            mean_q  <= mean_d;
            denom_q <= denom_d;
        end
    end

    assign gamma_o = gamma_q[raddr_i];
    assign beta_o  = beta_q[raddr_i];
    assign mean_o  = mean_q[raddr_i];
    assign denom_o = denom_q[raddr_i];

endmodule

// File: rtl/batch_normalization_sequencer.sv
// Feeds a channel-major feature map into batch_normalization_element with per-channel
// parameters and re-times the element's fixed-latency results into a valid/last stream.
module batch_normalization_sequencer
    import bn_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CHANNELS   = 8,
    parameter int SPATIAL    = 16,
    parameter int LATENCY    = 4
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              param_we_i,
    input  logic [1:0]                        param_sel_i,
    input  logic [addr_width(CHANNELS)-1:0]   param_addr_i,
    input  logic [DATA_WIDTH-1:0]             param_data_i,
    input  logic                              start_i,
    input  logic                              valid_i,
    input  logic [DATA_WIDTH-1:0]             data_i,
    output logic                              ready_o,
    output logic [DATA_WIDTH-1:0]             bn_data_o,
    output logic [DATA_WIDTH-1:0]             bn_gamma_o,
    output logic [DATA_WIDTH-1:0]             bn_beta_o,
    output logic [DATA_WIDTH-1:0]             bn_mean_o,
    output logic [DATA_WIDTH-1:0]             bn_denom_o,
    input  logic [DATA_WIDTH-1:0]             bn_result_i,
    output logic                              valid_o,
    output logic [DATA_WIDTH-1:0]             result_o,
    output logic                              last_o,
    output logic                              busy_o,
    output logic                              done_o
);

    localparam int CH_W = addr_width(CHANNELS);
    localparam int SP_W = addr_width(SPATIAL);
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(CHANNELS - 1);
    localparam logic [SP_W-1:0] SP_LAST = SP_W'(SPATIAL - 1);

    state_e                state_q, state_d;
    logic [SP_W-1:0]       sp_cnt_q, sp_cnt_d;
    logic [CH_W-1:0]       ch_cnt_q, ch_cnt_d;
    logic [DATA_WIDTH-1:0] bn_data_q, bn_data_d;
    logic [DATA_WIDTH-1:0] bn_gamma_q, bn_gamma_d;
    logic [DATA_WIDTH-1:0] bn_beta_q, bn_beta_d;
    logic [DATA_WIDTH-1:0] bn_mean_q, bn_mean_d;
    logic [DATA_WIDTH-1:0] bn_denom_q, bn_denom_d;
    tag_t                  tag_q [LATENCY+1];
    tag_t                  tag_d [LATENCY+1];
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  done_q, done_d;

    logic                  accept;
    logic                  last_beat;
    logic                  bank_we;
    logic [DATA_WIDTH-1:0] rd_gamma, rd_beta, rd_mean, rd_denom;

    bn_param_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .CHANNELS   (CHANNELS),
        .ADDR_WIDTH (CH_W)
    ) u_bank (
        .clk     (clk),
        .reset_n (reset_n),
        .we_i    (bank_we),
        .sel_i   (param_sel_i),
        .waddr_i (param_addr_i),
        .wdata_i (param_data_i),
        .raddr_i (ch_cnt_q),
        .gamma_o (rd_gamma),
        .beta_o  (rd_beta),
        .mean_o  (rd_mean),
        .denom_o (rd_denom)
    );

    always_comb begin
        accept     = valid_i && (state_q == S_RUN);
        last_beat  = (ch_cnt_q == CH_LAST) && (sp_cnt_q == SP_LAST);
        bank_we    = param_we_i && (state_q == S_IDLE);
        state_d    = state_q;
        sp_cnt_d   = sp_cnt_q;
        ch_cnt_d   = ch_cnt_q;
        bn_data_d  = bn_data_q;
        bn_gamma_d = bn_gamma_q;
        bn_beta_d  = bn_beta_q;
        bn_mean_d  = bn_mean_q;
        bn_denom_d = bn_denom_q;
        done_d     = 1'b0;

        // Stage 0 travels alongside the bn_* registers; stage LATENCY lines up with bn_result_i.
        tag_d[0].valid = accept;
        tag_d[0].last  = accept && last_beat;
        for (int i = 1; i <= LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end

        valid_d  = tag_q[LATENCY].valid;
        last_d   = tag_q[LATENCY].last;
        result_d = tag_q[LATENCY].valid ? bn_result_i : result_q;

        if (accept) begin
            bn_data_d  = data_i;
            bn_gamma_d = rd_gamma;
            bn_beta_d  = rd_beta;
            bn_mean_d  = rd_mean;
            bn_denom_d = rd_denom;
            if (sp_cnt_q == SP_LAST) begin
                sp_cnt_d = '0;
                ch_cnt_d = (ch_cnt_q == CH_LAST) ? '0 : ch_cnt_q + CH_W'(1);
            end else begin
                sp_cnt_d = sp_cnt_q + SP_W'(1);
            end
        end

        case (state_q)
            S_IDLE:  if (start_i) state_d = S_RUN;
            S_RUN:   if (accept && last_beat) state_d = S_DRAIN;
            // The final tag is the youngest, so its arrival means the pipe empties this edge.
            S_DRAIN: if (tag_q[LATENCY].valid && tag_q[LATENCY].last) begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            sp_cnt_q   <= '0;
            ch_cnt_q   <= '0;
            bn_data_q  <= '0;
            bn_gamma_q <= '0;
            bn_beta_q  <= '0;
            bn_mean_q  <= '0;
            bn_denom_q <= '0;
            for (int i = 0; i <= LATENCY; i++) begin
                tag_q[i] <= '0;
            end
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            result_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sp_cnt_q   <= sp_cnt_d;
            ch_cnt_q   <= ch_cnt_d;
            bn_data_q  <= bn_data_d;
            bn_gamma_q <= bn_gamma_d;
            bn_beta_q  <= bn_beta_d;
            bn_mean_q  <= bn_mean_d;
            bn_denom_q <= bn_denom_d;
            for (int i = 0; i <= LATENCY; i++) begin
                tag_q[i] <= tag_d[i];
            end
            valid_q    <= valid_d;
            last_q     <= last_d;
            result_q   <= result_d;
            done_q     <= done_d;
        end
    end

    assign ready_o    = (state_q == S_RUN);
    assign busy_o     = (state_q != S_IDLE);
    assign bn_data_o  = bn_data_q;
    assign bn_gamma_o = bn_gamma_q;
    assign bn_beta_o  = bn_beta_q;
    assign bn_mean_o  = bn_mean_q;
    assign bn_denom_o = bn_denom_q;
    assign valid_o    = valid_q;
    assign last_o     = last_q;
    assign result_o   = result_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_batch_normalization_sequencer.sv
// Scoreboard bench: element modelled as a LATENCY-deep pipe of a bit-mixing function of its inputs.
module tb_batch_normalization_sequencer;

    localparam int DW    = 32;
    localparam int CH    = 2;
    localparam int SP    = 2;
    localparam int LAT   = 4;
    localparam int TOTAL = CH * SP;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          param_we_i;
    logic [1:0]    param_sel_i;
    logic [0:0]    param_addr_i;
    logic [DW-1:0] param_data_i;
    logic          start_i;
    logic          valid_i;
    logic [DW-1:0] data_i;
    logic          ready_o;
    logic [DW-1:0] bn_data_o, bn_gamma_o, bn_beta_o, bn_mean_o, bn_denom_o;
    logic [DW-1:0] bn_result_i;
    logic          valid_o;
    logic [DW-1:0] result_o;
    logic          last_o;
    logic          busy_o;
    logic          done_o;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            cyc;
    } exp_t;

    exp_t          sb_q [$];
    logic [DW-1:0] model_bank [4][CH];
    logic [DW-1:0] elem_pipe [LAT];
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_err = 0;

    batch_normalization_sequencer #(
        .DATA_WIDTH (DW),
        .CHANNELS   (CH),
        .SPATIAL    (SP),
        .LATENCY    (LAT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .param_we_i   (param_we_i),
        .param_sel_i  (param_sel_i),
        .param_addr_i (param_addr_i),
        .param_data_i (param_data_i),
        .start_i      (start_i),
        .valid_i      (valid_i),
        .data_i       (data_i),
        .ready_o      (ready_o),
        .bn_data_o    (bn_data_o),
        .bn_gamma_o   (bn_gamma_o),
        .bn_beta_o    (bn_beta_o),
        .bn_mean_o    (bn_mean_o),
        .bn_denom_o   (bn_denom_o),
        .bn_result_i  (bn_result_i),
        .valid_o      (valid_o),
        .result_o     (result_o),
        .last_o       (last_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] elem_f(input logic [DW-1:0] d, g, b, m, n);
        return d ^ g ^ {b[30:0], b[31]} ^ {m[29:0], m[31:30]} ^ (n + 32'h0000_1357);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LAT; i++) elem_pipe[i] <= '0;
        end else begin
            elem_pipe[0] <= elem_f(bn_data_o, bn_gamma_o, bn_beta_o, bn_mean_o, bn_denom_o);
            for (int i = 1; i < LAT; i++) elem_pipe[i] <= elem_pipe[i-1];
        end
    end
    assign bn_result_i = elem_pipe[LAT-1];

    task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every valid_o must match the oldest outstanding expectation, on its cycle.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && valid_o) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("[TB] FAIL unexpected_valid: got result %h, required no output (cycle %0d)", result_o, cyc);
            end else begin
                e = sb_q.pop_front();
                check_output("result", result_o, e.data);
                check_output("last", {31'd0, last_o}, {31'd0, e.last});
                check_output("arrival_cycle", cyc, e.cyc);
                check_output("done_with_last", {31'd0, done_o}, {31'd0, e.last});
            end
        end else if (reset_n && done_o) begin
            check_output("done_without_valid", {31'd0, valid_o}, 32'd1);
        end
    end

    task automatic load_param(input logic [1:0] sel, input int ch, input logic [DW-1:0] val);
        @(negedge clk);
        param_we_i   = 1'b1;
        param_sel_i  = sel;
        param_addr_i = 1'(ch);
        param_data_i = val;
        model_bank[sel][ch] = val;
        @(negedge clk);
        param_we_i = 1'b0;
    endtask

    task automatic load_all;
        for (int c = 0; c < CH; c++) begin
            load_param(2'd0, c, 32'h3F80_0000 + 32'(c) * 32'h0080_0000);
            load_param(2'd1, c, 32'h1111_1111 * 32'(c + 1));
            load_param(2'd2, c, 32'h3E00_0000 + 32'(c) * 32'h0080_0000);
            load_param(2'd3, c, 32'h3F00_0000 + 32'(c) * 32'h0040_0000);
        end
    endtask

    // gap_mode 1 drives valid_i on alternate cycles; inject pokes param_we_i/start_i mid-map.
    task automatic apply_stimulus(input int gap_mode, input logic [DW-1:0] base, input bit inject);
        int  idx = 0;
        int  t = 0;
        int  ch;
        bit  acc;
        bit  got = 0;
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check_output("ready_in_run", {31'd0, ready_o}, 32'd1);
        while (idx < TOTAL && t < 64) begin
            valid_i      = (gap_mode == 0) || (t % 2 == 0);
            data_i       = base + 32'(idx);
            param_we_i   = inject && (idx == 1);
            param_sel_i  = 2'd0;
            param_addr_i = 1'b1;
            param_data_i = 32'hDEAD_BEEF;
            start_i      = inject && (idx == 1);
            ch           = idx / SP;
            acc          = valid_i && ready_o;
            if (acc) begin
                sb_q.push_back('{elem_f(data_i, model_bank[0][ch], model_bank[1][ch],
                                        model_bank[2][ch], model_bank[3][ch]),
                                 idx == TOTAL - 1, cyc + LAT + 2});
            end
            @(negedge clk);
            if (acc) begin
                check_output("bn_data", bn_data_o, base + 32'(idx));
                check_output("bn_gamma", bn_gamma_o, model_bank[0][ch]);
                check_output("bn_denom", bn_denom_o, model_bank[3][ch]);
                idx++;
            end
            t++;
        end
        valid_i    = 1'b0;
        param_we_i = 1'b0;
        start_i    = inject;
        check_output("beats_accepted", idx, TOTAL);
        check_output("drain_not_ready", {31'd0, ready_o}, 32'd0);
        check_output("drain_busy", {31'd0, busy_o}, 32'd1);
        @(negedge clk);
        start_i = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            if (done_o) got = 1;
            else @(negedge clk);
        end
        check_output("done_seen", {31'd0, got}, 32'd1);
        check_output("idle_after_done", {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n      = 1'b0;
        param_we_i   = 1'b0;
        param_sel_i  = 2'd0;
        param_addr_i = 1'b0;
        param_data_i = '0;
        start_i      = 1'b0;
        valid_i      = 1'b0;
        data_i       = '0;
        for (int s = 0; s < 4; s++) for (int c = 0; c < CH; c++) model_bank[s][c] = '0;
        #3;
        check_output("reset_ready", {31'd0, ready_o}, 32'd0);
        check_output("reset_busy", {31'd0, busy_o}, 32'd0);
        check_output("reset_valid", {31'd0, valid_o}, 32'd0);
        check_output("reset_result", result_o, 32'd0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;

        $display("[TB] back-to-back map with per-channel parameters");
        load_all();
        apply_stimulus(0, 32'h4100_0000, 1'b0);
        $display("[TB] alternating valid_i gaps, started right after done_o");
        apply_stimulus(1, 32'h4200_0000, 1'b0);
        $display("[TB] parameter write and start_i while busy are ignored");
        apply_stimulus(0, 32'h4300_0000, 1'b1);

        $display("[TB] reset in the middle of a map");
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1;
            data_i  = 32'h4400_0000 + 32'(i);
            @(negedge clk);
        end
        valid_i = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_output("abort_ready", {31'd0, ready_o}, 32'd0);
        check_output("abort_busy", {31'd0, busy_o}, 32'd0);
        check_output("abort_bn_data", bn_data_o, 32'd0);
        check_output("abort_bn_gamma", bn_gamma_o, 32'd0);
        check_output("abort_result", result_o, 32'd0);
        check_output("abort_done", {31'd0, done_o}, 32'd0);
        for (int s = 0; s < 4; s++) for (int c = 0; c < CH; c++) model_bank[s][c] = '0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (12) @(negedge clk);

        $display("[TB] map after reset uses a cleared bank, then reload");
        apply_stimulus(0, 32'h4500_0000, 1'b0);
        load_all();
        apply_stimulus(1, 32'h4600_0000, 1'b0);

        @(negedge clk);
        check_output("scoreboard_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
